// File: rtl/sobel_window_reader_if.sv
// Pixel-in / window-out bundle for the Sobel window reader.
// FrameDone exists only when FRAME_DONE_EN is defined.
interface sobel_window_reader_if #(
   parameter int DATA_WIDTH = 8
);
   logic                    Enable;
   logic [DATA_WIDTH-1:0]   DataIn;
   logic [9*DATA_WIDTH-1:0] Window;
   logic                    WindowValid;
`ifdef FRAME_DONE_EN
   logic                    FrameDone;
`endif

   modport master (
      output Enable, DataIn,
`ifdef FRAME_DONE_EN
      input  FrameDone,
`endif
      input  Window, WindowValid
   );

   modport slave (
      input  Enable, DataIn,
`ifdef FRAME_DONE_EN
      output FrameDone,
`endif
      output Window, WindowValid
   );
endinterface

// File: rtl/sobel_window_reader.sv
// Two line delays plus a 3x3 window register feeding the Sobel stage.
// Optional FRAME_DONE_EN adds a last-window-of-frame pulse.
module sobel_window_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int IMG_WIDTH  = 8,
   parameter int IMG_HEIGHT = 8,
   parameter int CNT_W      = 8
) (
   input logic                  CLK,
   input logic                  RST_N,
   sobel_window_reader_if.slave bus
);
   localparam logic [0:0] FILL   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   logic [CNT_W-1:0]      col;
   logic [CNT_W-1:0]      row;
   logic [0:0]            state;
   logic [DATA_WIDTH-1:0] ld0 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] ld1 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0] win [9];
   logic                  validReg;
   logic                  accept;
   logic                  lastCol;
   logic                  lastRow;
   logic                  winHit;

   assign accept  = bus.Enable;
   assign lastCol = (col == CNT_W'(IMG_WIDTH - 1));
   assign lastRow = (row == CNT_W'(IMG_HEIGHT - 1));
   assign winHit  = accept && (state == STREAM)
                    && (col >= CNT_W'(2));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         col   <= '0;
         row   <= '0;
         state <= FILL;
      end else if (accept) begin
         if (lastCol) begin
            col <= '0;
            row <= lastRow ? '0 : row + CNT_W'(1);
         end else begin
            col <= col + CNT_W'(1);
         end
         unique case (state)
            FILL:
               if (lastCol && row == CNT_W'(1))
                  state <= STREAM;
            STREAM:
               if (lastCol && lastRow)
                  state <= FILL;
            default: state <= FILL;
         endcase
      end
   end

   // Line delays advance only on accepted pixels, so stalls are invisible.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < IMG_WIDTH; i++) begin
            ld0[i] <= '0;
            ld1[i] <= '0;
         end
      end else if (accept) begin
         ld0[0] <= bus.DataIn;
         ld1[0] <= ld0[IMG_WIDTH-1];
         for (int i = 1; i < IMG_WIDTH; i++) begin
            ld0[i] <= ld0[i-1];
            ld1[i] <= ld1[i-1];
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int k = 0; k < 9; k++)
            win[k] <= '0;
      end else if (accept) begin
         win[0] <= win[1];
         win[1] <= win[2];
         win[2] <= ld1[IMG_WIDTH-1];
         win[3] <= win[4];
         win[4] <= win[5];
         win[5] <= ld0[IMG_WIDTH-1];
         win[6] <= win[7];
         win[7] <= win[8];
         win[8] <= bus.DataIn;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         validReg <= 1'b0;
      else
         validReg <= winHit;
   end

   always_comb begin
      bus.Window = '0;
      for (int k = 0; k < 9; k++)
         bus.Window[k*DATA_WIDTH +: DATA_WIDTH] = win[k];
   end

   assign bus.WindowValid = validReg;

`ifdef FRAME_DONE_EN
   logic doneReg;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         doneReg <= 1'b0;
      else
         doneReg <= winHit && lastCol && lastRow;
   end

   assign bus.FrameDone = doneReg;
`endif
endmodule

// File: tb/tb_sobel_window_reader.sv
// Scoreboard bench for sobel_window_reader (8x8 frames, pixel = 8*row+col).
// FrameDone checks are active only when FRAME_DONE_EN is defined.
module tb_sobel_window_reader;
   logic CLK = 1'b0;
   logic RST_N = 1'b0;

   int nTests = 0;
   int nFail  = 0;
   int mRow   = 0;
   int mCol   = 0;
   int nWin   = 0;
   int nFd    = 0;
   logic lastValid;

   logic [71:0] expWin [$];
   logic [71:0] obsSeq [$];
   logic [71:0] refSeq [$];

   sobel_window_reader_if #(.DATA_WIDTH(8)) tbIf ();

   sobel_window_reader #(
      .DATA_WIDTH(8),
      .IMG_WIDTH (8),
      .IMG_HEIGHT(8),
      .CNT_W     (8)
   ) dut (
      .CLK  (CLK),
      .RST_N(RST_N),
      .bus  (tbIf)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [7:0] pix(input int r, input int c);
      return 8'(8 * r + c);
   endfunction

   function automatic logic [71:0] mkWin(input int r, input int c);
      logic [71:0] w;
      w = '0;
      for (int k = 0; k < 9; k++)
         w[k*8 +: 8] = pix(r - 2 + k / 3, c - 2 + k % 3);
      return w;
   endfunction

   task automatic doReset();
      tbIf.Enable = 1'b0;
      tbIf.DataIn = '0;
      RST_N = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      mRow = 0;
      mCol = 0;
      nWin = 0;
      nFd  = 0;
      expWin.delete();
      obsSeq.delete();
   endtask

   task automatic drive(input bit en);
      bit expV;
      bit expF;
      logic [71:0] w;
      @(negedge CLK);
      tbIf.Enable = en;
      tbIf.DataIn = pix(mRow, mCol);
      expV = 1'b0;
      expF = 1'b0;
      if (en) begin
         if (mRow >= 2 && mCol >= 2) begin
            expWin.push_back(mkWin(mRow, mCol));
            expV = 1'b1;
            expF = (mRow == 7 && mCol == 7);
         end
         if (mCol == 7) begin
            mCol = 0;
            mRow = (mRow == 7) ? 0 : mRow + 1;
         end else begin
            mCol = mCol + 1;
         end
      end
      @(posedge CLK);
      #1;
      lastValid = tbIf.WindowValid;
      nTests++;
      if (tbIf.WindowValid !== expV) begin
         nFail++;
         $display("FAIL valid: got %b want %b (en=%b)",
                  tbIf.WindowValid, expV, en);
      end
      if (expWin.size() > 0) begin
         w = expWin.pop_front();
         if (tbIf.WindowValid === 1'b1) begin
            nTests++;
            if (tbIf.Window !== w) begin
               nFail++;
               $display("FAIL window: got %h want %h",
                        tbIf.Window, w);
            end
         end
      end
      if (tbIf.WindowValid === 1'b1) begin
         nWin++;
         obsSeq.push_back(tbIf.Window);
      end
`ifdef FRAME_DONE_EN
      nTests++;
      if (tbIf.FrameDone !== expF) begin
         nFail++;
         $display("FAIL frameDone: got %b want %b",
                  tbIf.FrameDone, expF);
      end
      if (tbIf.FrameDone === 1'b1)
         nFd++;
`endif
   endtask

   task automatic test_reset();
      logic [71:0] first;
      first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9,
               8'd8, 8'd2, 8'd1, 8'd0};
      tbIf.Enable = 1'b0;
      tbIf.DataIn = '0;
      RST_N = 1'b0;
      #1;
      nTests++;
      if (tbIf.Window !== '0 || tbIf.WindowValid !== 1'b0) begin
         nFail++;
         $display("FAIL resetState: win=%h valid=%b want 0/0",
                  tbIf.Window, tbIf.WindowValid);
      end
`ifdef FRAME_DONE_EN
      nTests++;
      if (tbIf.FrameDone !== 1'b0) begin
         nFail++;
         $display("FAIL resetDone: got %b want 0", tbIf.FrameDone);
      end
`endif
      doReset();
      for (int i = 0; i < 20; i++)
         drive(1'b1);
      @(negedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      nTests++;
      if (tbIf.Window !== '0 || tbIf.WindowValid !== 1'b0) begin
         nFail++;
         $display("FAIL asyncReset: win=%h valid=%b want 0/0",
                  tbIf.Window, tbIf.WindowValid);
      end
      doReset();
      for (int i = 0; i < 18; i++)
         drive(1'b1);
      nTests++;
      if (nWin !== 0) begin
         nFail++;
         $display("FAIL earlyWindow: got %0d want 0", nWin);
      end
      drive(1'b1);
      nTests++;
      if (nWin !== 1 || obsSeq[0] !== first) begin
         nFail++;
         $display("FAIL postResetFirst: n=%0d win=%h want 1 %h",
                  nWin, tbIf.Window, first);
      end
   endtask

   task automatic test_stream();
      logic [71:0] first;
      first = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9,
               8'd8, 8'd2, 8'd1, 8'd0};
      doReset();
      for (int i = 0; i < 64; i++)
         drive(1'b1);
      nTests++;
      if (nWin !== 36) begin
         nFail++;
         $display("FAIL streamCount: got %0d want 36", nWin);
      end
      nTests++;
      if (obsSeq.size() == 0 || obsSeq[0] !== first) begin
         nFail++;
         $display("FAIL streamFirst: got %h want %h",
                  (obsSeq.size() > 0) ? obsSeq[0] : 72'h0, first);
      end
      refSeq = obsSeq;
   endtask

   task automatic test_gaps();
      int acc;
      int guard;
      acc = 0;
      guard = 0;
      doReset();
      while (acc < 64 && guard < 1000) begin
         if ($urandom_range(0, 2) != 0) begin
            drive(1'b1);
            acc++;
         end else begin
            drive(1'b0);
         end
         guard++;
      end
      nTests++;
      if (acc !== 64) begin
         nFail++;
         $display("FAIL gapBudget: accepted %0d want 64", acc);
      end
      nTests++;
      if (nWin !== 36) begin
         nFail++;
         $display("FAIL gapCount: got %0d want 36", nWin);
      end
      for (int i = 0; i < obsSeq.size() && i < refSeq.size(); i++) begin
         nTests++;
         if (obsSeq[i] !== refSeq[i]) begin
            nFail++;
            $display("FAIL gapSeq[%0d]: got %h want %h",
                     i, obsSeq[i], refSeq[i]);
         end
      end
   endtask

   task automatic test_row_wrap();
      logic [71:0] want;
      want = {8'd26, 8'd25, 8'd24, 8'd18, 8'd17,
              8'd16, 8'd10, 8'd9, 8'd8};
      doReset();
      for (int i = 0; i < 24; i++)
         drive(1'b1);
      drive(1'b1);
      nTests++;
      if (lastValid !== 1'b0) begin
         nFail++;
         $display("FAIL wrap30: got %b want 0", lastValid);
      end
      drive(1'b1);
      nTests++;
      if (lastValid !== 1'b0) begin
         nFail++;
         $display("FAIL wrap31: got %b want 0", lastValid);
      end
      drive(1'b1);
      nTests++;
      if (lastValid !== 1'b1 || tbIf.Window !== want) begin
         nFail++;
         $display("FAIL wrap32: valid=%b win=%h want 1 %h",
                  lastValid, tbIf.Window, want);
      end
   endtask

   task automatic test_back_to_back();
      doReset();
      for (int i = 0; i < 128; i++)
         drive(1'b1);
      nTests++;
      if (nWin !== 72) begin
         nFail++;
         $display("FAIL b2bCount: got %0d want 72", nWin);
      end
      for (int i = 0; i < 36 && i + 36 < obsSeq.size(); i++) begin
         nTests++;
         if (obsSeq[i+36] !== refSeq[i]) begin
            nFail++;
            $display("FAIL b2bSeq[%0d]: got %h want %h",
                     i, obsSeq[i+36], refSeq[i]);
         end
      end
`ifdef FRAME_DONE_EN
      nTests++;
      if (nFd !== 2) begin
         nFail++;
         $display("FAIL b2bDone: got %0d want 2", nFd);
      end
`endif
   endtask

   initial begin
      tbIf.Enable = 1'b0;
      tbIf.DataIn = '0;
      test_reset();
      test_stream();
      test_gaps();
      test_row_wrap();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule
